// File: rtl/inv_key_schedule.sv
// inv_key_schedule
//   Walks the AES-128 key expansion backwards. It is loaded with the final
//   (round-10) round key and then produces round keys 9 down to 0, one key per
//   enabled cycle. This lets the inverse cipher get its keys without storing
//   the whole expanded key.
//
// Ports
//   clk       : clock; all state updates happen on the rising edge
//   rst       : synchronous, active-high reset; overrides every other input
//   enable    : qualifies every register update; when it is low, everything holds
//   load      : with enable high, capture key_in as the round-`rounds` key
//   key_in    : final round key (round 10)
//   key_out   : current round key (registered)
//   round_out : round index of key_out
//   valid     : key_out holds a legal round key
//   done      : key_out holds the round-0 key (the original cipher key)
//
// Handshake: there is no back-pressure. A load is accepted on any edge where
// enable && load is high. After that, each edge with enable high and load low
// moves one round back, until round 0 is reached.
module inv_key_schedule #(
    parameter int word_size  = 8,
    parameter int array_size = 16,   // only 16 (AES-128) is supported
    parameter int rounds     = 10
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic                            load,
    input  logic [word_size*array_size-1:0] key_in,
    output logic [word_size*array_size-1:0] key_out,
    output logic [3:0]                      round_out,
    output logic                            valid,
    output logic                            done
);

    localparam int KW = word_size * array_size;

    // Forward AES S-box. Byte 0 sits in the top 8 bits.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[2047 - 8 * int'(x) -: 8];
    endfunction

    // Out-of-range indices return 00. They cannot occur while stepping.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // One backward step. Words k1..k3 of key r-1 are recovered by XORing
    // neighbouring words of key r. Recovered word 3 then feeds the g() function,
    // which needs Rcon of the round being undone (r).
    logic [31:0] k0, k1, k2, k3;
    logic [31:0] p0, p1, p2, p3;
    logic [31:0] rot, sub;
    logic [KW-1:0] step_key;

    assign k0 = key_out[127:96];
    assign k1 = key_out[95:64];
    assign k2 = key_out[63:32];
    assign k3 = key_out[31:0];

    assign p3  = k3 ^ k2;
    assign p2  = k2 ^ k1;
    assign p1  = k1 ^ k0;
    assign rot = {p3[23:0], p3[31:24]};
    assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    assign p0  = k0 ^ sub ^ {rcon(round_out), 24'h0};

    assign step_key = {p0, p1, p2, p3};

    always_ff @(posedge clk) begin
        if (rst) begin
            key_out   <= '0;
            round_out <= '0;
            valid     <= 1'b0;
            done      <= 1'b0;
            state     <= IDLE;
        end else if (enable) begin
            // A load wins over stepping in every state.
            if (load) begin
                key_out   <= key_in;
                round_out <= 4'(rounds);
                valid     <= 1'b1;
                done      <= 1'b0;
                state     <= RUN;
            end else if (state == RUN) begin
                key_out   <= step_key;
                round_out <= round_out - 4'd1;
                if (round_out == 4'd1) begin
                    done  <= 1'b1;
                    state <= DONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_inv_key_schedule.sv
// Testbench for inv_key_schedule. The reference model expands a cipher key
// forward into a table of round keys. The S-box in the model comes from the
// GF(2^8) inverse plus the affine transform, not from a table. The model then
// tracks which round index the design should be showing.
module tb_inv_key_schedule;

    logic         clk;
    logic         rst;
    logic         enable;
    logic         load;
    logic [127:0] key_in;
    logic [127:0] key_out;
    logic [3:0]   round_out;
    logic         valid;
    logic         done;

    inv_key_schedule #(.word_size(8), .array_size(16), .rounds(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .load      (load),
        .key_in    (key_in),
        .key_out   (key_out),
        .round_out (round_out),
        .valid     (valid),
        .done      (done)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    int           n_chk = 0;
    int           n_err = 0;
    logic [7:0]   sbox_m [256];
    logic [127:0] rk      [11];   // latest forward-expanded key table
    logic [127:0] cur_tab [11];   // table captured at the last accepted load
    int           m_round;
    logic         m_valid;
    logic         m_done;
    logic [127:0] m_key;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Forward FIPS-197 key expansion: rk[r] is the round-r key.
    task automatic expand(input logic [127:0] ck);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = ck[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver: one clock cycle plus model update ----------------
    task automatic cyc(input logic e, input logic l, input logic r, input logic [127:0] k,
                       input string tag);
        @(negedge clk);
        enable = e;
        load   = l;
        rst    = r;
        key_in = k;
        @(posedge clk);
        #1;
        if (r) begin
            m_valid = 1'b0;
            m_round = 0;
            m_done  = 1'b0;
        end else if (e) begin
            if (l) begin
                m_valid = 1'b1;
                m_round = 10;
                m_done  = 1'b0;
                cur_tab = rk;
            end else if (m_valid && m_round > 0) begin
                m_round--;
                if (m_round == 0) m_done = 1'b1;
            end
        end
        m_key = m_valid ? cur_tab[m_round] : 128'h0;
        check({tag, ".key"},   key_out,          m_key);
        check({tag, ".round"}, 128'(round_out),  128'(m_round));
        check({tag, ".valid"}, 128'(valid),      128'(m_valid));
        check({tag, ".done"},  128'(done),       128'(m_done));
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus ----------------
    localparam logic [127:0] FIPS_CK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] SEQ_CK   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] SEQ_R10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    initial begin
        rst = 1'b1; enable = 1'b0; load = 1'b0; key_in = '0;
        m_round = 0; m_valid = 1'b0; m_done = 1'b0; m_key = '0;
        build_sbox();
        for (int r = 0; r < 11; r++) cur_tab[r] = '0;

        // Reset state.
        cyc(0, 0, 1, '0, "reset");
        cyc(1, 0, 1, '0, "reset2");

        // FIPS-197 A.1 vector.
        expand(FIPS_CK);
        check("model_fips_r10", rk[10], FIPS_R10);
        cyc(1, 1, 0, FIPS_R10, "fips_load");
        check("fips_c1", key_out, FIPS_R10);
        for (int i = 1; i <= 10; i++) begin
            cyc(1, 0, 0, rnd128(), "fips_step");
            if (i == 1)  check("fips_c2",  key_out, 128'hac7766f319fadc2128d12941575c006e);
            if (i == 9)  check("fips_c10", key_out, 128'ha0fafe1788542cb123a339392a6c7605);
            if (i == 10) check("fips_c11", key_out, FIPS_CK);
        end
        check("fips_done", 128'(done), 128'(1));

        // Hold after done.
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, rnd128(), "hold");

        // Stall: enable 1,0,0,1 and then random, until round 0.
        cyc(1, 1, 0, FIPS_R10, "stall_load");
        cyc(1, 0, 0, '0, "stall");
        cyc(0, 0, 0, '0, "stall");
        cyc(0, 1, 0, rnd128(), "stall");
        for (int i = 0; i < 200 && !m_done; i++)
            cyc(1'($urandom_range(0, 1)), 0, 0, rnd128(), "stall");
        check("stall_final", key_out, FIPS_CK);

        // Reload mid-run at round 6.
        cyc(1, 1, 0, FIPS_R10, "reload_a");
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, '0, "reload_run");
        check("reload_r6", 128'(round_out), 128'(6));
        expand(SEQ_CK);
        check("model_seq_r10", rk[10], SEQ_R10);
        cyc(1, 1, 0, SEQ_R10, "reload_b");
        check("reload_r10", 128'(round_out), 128'(10));
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, '0, "reload_step");
        check("reload_final", key_out, SEQ_CK);

        // Reset at round 4, then stay idle without a load.
        expand(FIPS_CK);
        cyc(1, 1, 0, FIPS_R10, "rst_load");
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, '0, "rst_run");
        check("rst_r4", 128'(round_out), 128'(4));
        cyc(1, 0, 1, '0, "rst_mid");
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, rnd128(), "rst_idle");

        // load while enable is low: nothing is captured.
        cyc(0, 1, 0, FIPS_R10, "noen_idle");
        cyc(1, 1, 0, FIPS_R10, "noen_load");
        cyc(1, 0, 0, '0, "noen_run");
        cyc(1, 0, 0, '0, "noen_run");
        expand(rnd128());
        cyc(0, 1, 0, rk[10], "noen_mid");
        cyc(0, 1, 0, rk[10], "noen_mid");

        // Random cipher keys with random enable gaps.
        for (int t = 0; t < 4; t++) begin
            expand(rnd128());
            cyc(1, 1, 0, rk[10], "rand_load");
            for (int i = 0; i < 200 && !m_done; i++)
                cyc(1'($urandom_range(0, 1)), 0, 0, rnd128(), "rand_step");
            check("rand_done", 128'(done), 128'(1));
            check("rand_key0", key_out, rk[0]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/inv_key_schedule.md
Name: inv_key_schedule

Overview:
- Runs the AES-128 key expansion in reverse for the decryption datapath.
- Loaded with the final (round-10) round key, it produces round keys 9, 8, …, 0 one per enabled cycle.
- These keys feed the round-key AddRoundKey stage in the inverse cipher, so the full 176-byte expanded key never has to be stored.

Parameters:
- word_size, 8, bits per state byte.
- array_size, 16, bytes per key/state. Only 16 (AES-128) is supported.
- rounds, 10, index of the final round loaded via key_in.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- enable  input  1  advance/capture qualifier; when low, all registers hold.
- load  input  1  with enable high, capture key_in as round `rounds` key.
- key_in  input  word_size*array_size  final round key (round 10).
- key_out  output  word_size*array_size  current round key.
- round_out  output  4  round index of key_out.
- valid  output  1  key_out holds a legal round key.
- done  output  1  key_out holds round-0 key (original cipher key).

Behaviour:
- Byte order: byte 0 = bits [127:120] (FIPS-197 hex-string order).
- Word j = bits [127-32j -: 32], for j = 0..3; byte 0 of a word is its MSB.
- Reset (rst=1 at edge, overrides everything):
  - key_out=0, round_out=0, valid=0, done=0.
  - FSM state = IDLE.
- FSM states: IDLE, RUN, DONE.
- IDLE: enable&load -> RUN, with:
  - key_out<=key_in
  - round_out<=rounds
  - valid<=1, done<=0
  - Otherwise hold.
- RUN, enable=1, load=0: one backward step per cycle.
  - Inputs: key_out = words k0..k3, round r = round_out.
  - p3=k3^k2; p2=k2^k1; p1=k1^k0.
  - p0 = k0 ^ SubWord(RotWord(p3)) ^ {Rcon[r],24'h0}.
    - RotWord = rotate left 8 bits.
    - SubWord = forward AES S-box on each byte.
    - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
  - key_out<={p0,p1,p2,p3}; round_out<=r-1.
  - When r-1==0: done<=1 and state -> DONE.
- DONE: enable=1, load=0 holds key_out/round_out/done/valid. No further stepping and no wrap to round 10.
- load has priority over stepping in every state: enable&load in RUN or DONE restarts at round `rounds` and clears done.
- enable=0: every register holds regardless of load.
- Latency:
  - Round-10 key visible 1 cycle after load.
  - Round-k key visible (rounds-k) enabled cycles after that.
  - Round 0 at cycle 11 after the load edge if enable is held high.
- Timing: key_out is combinationally independent of key_in (registered). The S-box lookup is combinational within the step cycle (single-cycle step).
- rst asserted mid-sequence: next cycle is the reset state; a new load is required.
- Rcon lookup for r outside 1..10: returns 00. This is unreachable in RUN.

Test Plan:
1. FIPS-197 A.1 vector: key_in=d014f9a8c9ee2589e13f0cc8b6630ca6, enable&load, then enable held.
   - Cycle 1: key_out=d014f9a8…, round_out=10.
   - Cycle 2: ac7766f319fadc2128d12941575c006e, round 9.
   - Cycle 10: a0fafe1788542cb123a339392a6c7605, round 1.
   - Cycle 11: 2b7e151628aed2a6abf7158809cf4f3c, round 0, done=1.
2. Stall: same load, enable toggled 1,0,0,1… -> key_out/round_out change only on enable=1 cycles. The final key equals the case-1 sequence; total enabled steps = 10.
3. Hold after done: keep enable=1 for 5 more cycles after case 1 -> key_out stays 2b7e1516…, round_out=0, done=1.
4. Reload mid-run: at round_out=6, assert enable&load with key_in=13111d7fe3944a17f307a78b4d2b30c5 (AES-128 key 000102…0f round 10).
   - Next cycle: round_out=10, done=0.
   - 10 steps later: key_out=000102030405060708090a0b0c0d0e0f.
5. Reset: rst=1 at round_out=4 -> next cycle key_out=0, round_out=0, valid=0, done=0. With enable=1, load=0, outputs stay 0 until a load.
6. load while enable=0: no capture, outputs unchanged.
